// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch-flush kill.
// Captures register-file read data and decoded fields for EX one cycle later.
// Inserts a one-cycle bubble on a load-use hazard or a flush and counts bubbles.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [7:0]       id_ctrl,
    input  logic [3:0]       id_funct,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic [7:0]       ex_ctrl,
    output logic [3:0]       ex_funct,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [7:0]      ctrl;
        logic [3:0]      funct;
    } ex_pkt_t;

    ex_pkt_t         ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            hazard;
    logic            kill;

    // Load in EX (memRead = ctrl[1]) whose non-zero rd feeds an ID source.
    always_comb begin
        hazard = ex_q.valid & ex_q.ctrl[1] & (ex_q.rd != '0) & id_valid &
                 ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
        stall  = hazard & ~flush;
        kill   = flush | stall;
    end

    // Next EX contents: bubble on flush, stall or empty ID; otherwise capture ID.
    always_comb begin
        ex_d = '0;
        if (!kill && id_valid) begin
            ex_d.valid = 1'b1;
            ex_d.pc    = id_pc;
            ex_d.rd1   = id_rd1;
            ex_d.rd2   = id_rd2;
            ex_d.imm   = id_imm;
            ex_d.rs1   = id_rs1;
            ex_d.rs2   = id_rs2;
            ex_d.rd    = id_rd;
            ex_d.ctrl  = id_ctrl;
            ex_d.funct = id_funct;
        end
    end

    // Bubble counter: counts only stall/flush bubbles, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (kill && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Pipeline register and counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_pc      = ex_q.pc;
    assign ex_rd1     = ex_q.rd1;
    assign ex_rd2     = ex_q.rd2;
    assign ex_imm     = ex_q.imm;
    assign ex_rs1     = ex_q.rs1;
    assign ex_rs2     = ex_q.rs2;
    assign ex_rd      = ex_q.rd;
    assign ex_ctrl    = ex_q.ctrl;
    assign ex_funct   = ex_q.funct;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stall, x0/store
// exemptions, flush priority, async reset and counter saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [63:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [7:0]  id_ctrl;
    logic [3:0]  id_funct;
    logic        flush;

    logic        ex_valid, ex_valid_s;
    logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [63:0] ex_pc_s, ex_rd1_s, ex_rd2_s, ex_imm_s;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_rs1_s, ex_rs2_s, ex_rd_s;
    logic [7:0]  ex_ctrl, ex_ctrl_s;
    logic [3:0]  ex_funct, ex_funct_s;
    logic        stall, stall_s;
    logic [31:0] bubble_cnt;
    logic [3:0]  bubble_cnt_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(64), .RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl), .id_funct(id_funct),
        .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_funct(ex_funct), .stall(stall),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.XLEN(64), .RA_W(5), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl), .id_funct(id_funct),
        .flush(flush), .ex_valid(ex_valid_s), .ex_pc(ex_pc_s), .ex_rd1(ex_rd1_s),
        .ex_rd2(ex_rd2_s), .ex_imm(ex_imm_s), .ex_rs1(ex_rs1_s), .ex_rs2(ex_rs2_s),
        .ex_rd(ex_rd_s), .ex_ctrl(ex_ctrl_s), .ex_funct(ex_funct_s), .stall(stall_s),
        .bubble_cnt(bubble_cnt_s)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present an ID instruction; settle combinational outputs.
    task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [7:0] ctrl, input logic [63:0] pc);
        id_valid = v;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_ctrl  = ctrl;
        id_pc    = pc;
        id_rd1   = {59'd0, rs1} + 64'h1000;
        id_rd2   = {59'd0, rs2} + 64'h2000;
        id_imm   = 64'hFFFF_FFFF_FFFF_FFF0;
        id_funct = 4'hA;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
        chk({tag, "_ctrl"},  {56'd0, ex_ctrl}, 64'd0);
        chk({tag, "_rd"},    {59'd0, ex_rd}, 64'd0);
        chk({tag, "_pc"},    ex_pc, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        id_set(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 64'd0);
        #10;
        chk("rst_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_cnt",   {32'd0, bubble_cnt}, 64'd0);
        chk("rst_rd1",   ex_rd1, 64'd0);
        reset = 1'b0;
        tick();

        // pass-through: ALU op, rs1=3, rd=7
        id_set(1'b1, 5'd3, 5'd1, 5'd7, 8'h01, 64'h100);
        chk("pt_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("pt_valid", {63'd0, ex_valid}, 64'd1);
        chk("pt_rd",    {59'd0, ex_rd}, 64'd7);
        chk("pt_rd1",   ex_rd1, 64'h1003);
        chk("pt_rd2",   ex_rd2, 64'h2001);
        chk("pt_pc",    ex_pc, 64'h100);
        chk("pt_imm",   ex_imm, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("pt_funct", {60'd0, ex_funct}, 64'hA);
        chk("pt_ctrl",  {56'd0, ex_ctrl}, 64'h01);

        // load-use via rs1: ld x5 then add x6,x5,x4
        id_set(1'b1, 5'd2, 5'd0, 5'd5, 8'h0B, 64'h104);
        tick();
        chk("ld_ctrl", {56'd0, ex_ctrl}, 64'h0B);
        id_set(1'b1, 5'd5, 5'd4, 5'd6, 8'h01, 64'h108);
        chk("lu_stall", {63'd0, stall}, 64'd1);
        tick();
        chk_bubble("lu_bub");
        chk("lu_cnt", {32'd0, bubble_cnt}, 64'd1);
        chk("lu_stall_drop", {63'd0, stall}, 64'd0);
        tick();
        chk("lu_cap_rd",    {59'd0, ex_rd}, 64'd6);
        chk("lu_cap_valid", {63'd0, ex_valid}, 64'd1);
        chk("lu_cap_cnt",   {32'd0, bubble_cnt}, 64'd1);

        // ld x0 followed by consumer of x0: no hazard
        id_set(1'b1, 5'd2, 5'd0, 5'd0, 8'h0B, 64'h10C);
        tick();
        id_set(1'b1, 5'd0, 5'd0, 5'd6, 8'h01, 64'h110);
        chk("x0_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("x0_cap", {59'd0, ex_rd}, 64'd6);

        // store with rd field=5 in EX, consumer of x5 in ID: no hazard
        id_set(1'b1, 5'd2, 5'd3, 5'd5, 8'h24, 64'h114);
        tick();
        id_set(1'b1, 5'd5, 5'd5, 5'd9, 8'h01, 64'h118);
        chk("st_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("st_cap", {59'd0, ex_rd}, 64'd9);

        // empty ID: bubble without counting
        id_set(1'b0, 5'd1, 5'd1, 5'd1, 8'h01, 64'h11C);
        tick();
        chk_bubble("idle_bub");
        chk("idle_cnt", {32'd0, bubble_cnt}, 64'd1);

        // flush during load-use: flush wins, still counted
        id_set(1'b1, 5'd2, 5'd0, 5'd5, 8'h0B, 64'h120);
        tick();
        id_set(1'b1, 5'd1, 5'd5, 5'd6, 8'h01, 64'h124);
        chk("fl_prestall", {63'd0, stall}, 64'd1);
        flush = 1'b1;
        #1;
        chk("fl_stall", {63'd0, stall}, 64'd0);
        tick();
        flush = 1'b0;
        chk_bubble("fl_bub");
        chk("fl_cnt", {32'd0, bubble_cnt}, 64'd2);

        // load-use via rs2
        id_set(1'b1, 5'd2, 5'd0, 5'd8, 8'h0B, 64'h128);
        tick();
        id_set(1'b1, 5'd1, 5'd8, 5'd6, 8'h01, 64'h12C);
        chk("rs2_stall", {63'd0, stall}, 64'd1);
        tick();
        chk("rs2_cnt", {32'd0, bubble_cnt}, 64'd3);
        chk("rs2_valid", {63'd0, ex_valid}, 64'd0);

        // reset asserted mid-stall clears immediately
        id_set(1'b1, 5'd2, 5'd0, 5'd5, 8'h0B, 64'h130);
        tick();
        id_set(1'b1, 5'd5, 5'd0, 5'd6, 8'h01, 64'h134);
        chk("mr_prestall", {63'd0, stall}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_stall", {63'd0, stall}, 64'd0);
        chk("mr_valid", {63'd0, ex_valid}, 64'd0);
        chk("mr_ctrl",  {56'd0, ex_ctrl}, 64'd0);
        chk("mr_cnt",   {32'd0, bubble_cnt}, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("post_rst_cap", {59'd0, ex_rd}, 64'd6);

        // 17 consecutive flushes: 4-bit counter saturates, 32-bit counts on
        flush = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        flush = 1'b0;
        chk("sat_cnt4",  {60'd0, bubble_cnt_s}, 64'hF);
        chk("sat_cnt32", {32'd0, bubble_cnt}, 64'd17);
        chk("sat_valid", {63'd0, ex_valid_s}, 64'd0);
        tick();
        chk("sat_hold", {60'd0, bubble_cnt_s}, 64'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
